// File: rtl/sincronizador_vga_pkg.sv
// Shared VGA 640x480@60 Hz timing constants, also used by the drawing stages for MAX_X/MAX_Y.
package sincronizador_vga_pkg;

    localparam int CNT_W = 10;
    localparam int DIV_W = 4;

    localparam int PIX_DIV_DEF = 4;

    localparam int H_DISP_DEF = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int H_TOTAL    = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_DISP_DEF = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;
    localparam int V_TOTAL    = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int MAX_X = H_DISP_DEF - 1;
    localparam int MAX_Y = V_DISP_DEF - 1;

    function automatic logic en_ventana(
        input logic [CNT_W-1:0] valor,
        input logic [CNT_W-1:0] ini,
        input logic [CNT_W-1:0] fin
    );
        return (valor >= ini) && (valor <= fin);
    endfunction

endpackage

// File: rtl/generador_tick_pixel.sv
// Pixel-rate enable: one-clk pulse every PIX_DIV system clocks, suppressed while in reset.
module generador_tick_pixel
    import sincronizador_vga_pkg::*;
#(
    parameter int PIX_DIV = PIX_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic o_p_tick
);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_fin;

    assign w_fin = (r_div_cnt == C_DIV_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt <= '0;
        end else if (w_fin) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_p_tick = w_fin && reset;

endmodule

// File: rtl/sincronizador_vga.sv
// VGA scan counters with sync/blank outputs registered from the next count, so they stay
// coherent with pixel_x/pixel_y; line/frame strobes mark the last pixel of a line/frame.
module sincronizador_vga
    import sincronizador_vga_pkg::*;
#(
    parameter int   PIX_DIV  = PIX_DIV_DEF,
    parameter int   H_DISP   = H_DISP_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_DISP   = V_DISP_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_tick,
    output logic             frame_tick
);

    localparam logic [CNT_W-1:0] C_H_DISP = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] C_HS_INI = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] C_HS_FIN = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] C_V_DISP = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_DISP + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] C_VS_INI = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] C_VS_FIN = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

    logic             w_p_tick;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic [CNT_W-1:0] w_x_next;
    logic [CNT_W-1:0] w_y_next;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             w_fin_linea;

    generador_tick_pixel #(
        .PIX_DIV (PIX_DIV)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .o_p_tick (w_p_tick)
    );

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        w_x_next = r_x + 1'b1;
        w_y_next = r_y;
        if (r_x == C_H_LAST) begin
            w_x_next = '0;
            w_y_next = (r_y == C_V_LAST) ? '0 : r_y + 1'b1;
        end
    end

    // Decoding the next count keeps the registered outputs aligned with the counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_hsync    <= ~SYNC_POL;
            r_vsync    <= ~SYNC_POL;
            r_video_on <= 1'b0;
        end else if (w_p_tick) begin
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_hsync    <= en_ventana(w_x_next, C_HS_INI, C_HS_FIN) ? SYNC_POL : ~SYNC_POL;
            r_vsync    <= en_ventana(w_y_next, C_VS_INI, C_VS_FIN) ? SYNC_POL : ~SYNC_POL;
            r_video_on <= (w_x_next < C_H_DISP) && (w_y_next < C_V_DISP);
        end
    end

    assign w_fin_linea = w_p_tick && (r_x == C_H_LAST);

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign p_tick     = w_p_tick;
    assign pixel_x    = r_x;
    assign pixel_y    = r_y;
    assign line_tick  = w_fin_linea;
    assign frame_tick = w_fin_linea && (r_y == C_V_LAST);

endmodule

// File: tb/tb_sincronizador_vga.sv
// Directed bench: default-timing instance for divider/horizontal/reset checks, and a
// PIX_DIV=1 instance with a shortened vertical frame for vsync and frame_tick checks.
module tb_sincronizador_vga;

    logic       clk;
    logic       rst_a;
    logic       rst_b;

    logic       hs_a, vs_a, vo_a, pt_a, lt_a, ft_a;
    logic [9:0] x_a, y_a;
    logic       hs_b, vs_b, vo_b, pt_b, lt_b, ft_b;
    logic [9:0] x_b, y_b;

    int n_checks = 0;
    int n_errors = 0;

    sincronizador_vga u_dut_a (
        .clk        (clk),
        .reset      (rst_a),
        .hsync      (hs_a),
        .vsync      (vs_a),
        .video_on   (vo_a),
        .p_tick     (pt_a),
        .pixel_x    (x_a),
        .pixel_y    (y_a),
        .line_tick  (lt_a),
        .frame_tick (ft_a)
    );

    // Vertical frame shortened to 10 lines: visible 0..3, vsync on lines 6..7.
    sincronizador_vga #(
        .PIX_DIV (1),
        .V_DISP  (4),
        .V_FP    (2),
        .V_SYNC  (2),
        .V_BP    (2)
    ) u_dut_b (
        .clk        (clk),
        .reset      (rst_b),
        .hsync      (hs_b),
        .vsync      (vs_b),
        .video_on   (vo_b),
        .p_tick     (pt_b),
        .pixel_x    (x_b),
        .pixel_y    (y_b),
        .line_tick  (lt_b),
        .frame_tick (ft_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs_low, hs_min, hs_max, vo_low, lt_cnt, lt_at, incoh;
        int vs_low, vs_min, vs_max, ft_cnt, ft_at, first_lt, pt_zero;
        int xi, yi;

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(negedge clk);

        check("rst_x", int'(x_a), 0);
        check("rst_y", int'(y_a), 0);
        check("rst_hsync", int'(hs_a), 1);
        check("rst_vsync", int'(vs_a), 1);
        check("rst_video_on", int'(vo_a), 0);
        check("rst_p_tick", int'(pt_a), 0);
        check("rst_line_tick", int'(lt_a), 0);
        check("rst_frame_tick", int'(ft_a), 0);

        // Divider: p_tick on the 3rd, 7th... edge after release; counters step on the next.
        rst_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("div_p_tick_k%0d", k), int'(pt_a), (k % 4 == 3) ? 1 : 0);
            check($sformatf("div_x_k%0d", k), int'(x_a), k / 4);
            check($sformatf("div_video_on_k%0d", k), int'(vo_a), (k >= 4) ? 1 : 0);
        end

        n = 0;
        while (!lt_a && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("line_tick_found", int'(lt_a), 1);
        check("line_tick_x", int'(x_a), 799);

        // One full line (y=1): sync window, blanking and line period.
        hs_low = 0; hs_min = 1023; hs_max = 0; vo_low = 0; lt_cnt = 0; lt_at = 0; incoh = 0;
        for (int i = 1; i <= 3200; i++) begin
            @(negedge clk);
            xi = int'(x_a);
            yi = int'(y_a);
            if (!hs_a) begin
                hs_low++;
                if (xi < hs_min) hs_min = xi;
                if (xi > hs_max) hs_max = xi;
            end
            if (!vo_a) vo_low++;
            if (lt_a) begin
                lt_cnt++;
                lt_at = i;
            end
            if (vo_a !== ((xi < 640 && yi < 480) ? 1'b1 : 1'b0)) incoh++;
            if (hs_a !== ((xi >= 656 && xi <= 751) ? 1'b0 : 1'b1)) incoh++;
        end
        check("h_line_y", int'(y_a), 1);
        check("h_hsync_low_clks", hs_low, 384);
        check("h_hsync_first_x", hs_min, 656);
        check("h_hsync_last_x", hs_max, 751);
        check("h_video_off_clks", vo_low, 640);
        check("h_line_tick_count", lt_cnt, 1);
        check("h_line_period", lt_at, 3200);
        check("h_incoherent", incoh, 0);

        // Reset in the middle of a line.
        n = 0;
        while (x_a != 10'd300 && n < 1300) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_x300", int'(x_a), 300);
        rst_a = 1'b0;
        @(negedge clk);
        check("mid_rst_x", int'(x_a), 0);
        check("mid_rst_y", int'(y_a), 0);
        check("mid_rst_video_on", int'(vo_a), 0);
        check("mid_rst_hsync", int'(hs_a), 1);
        check("mid_rst_vsync", int'(vs_a), 1);
        check("mid_rst_p_tick", int'(pt_a), 0);
        rst_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("mid_p_tick_k%0d", k), int'(pt_a), (k == 3) ? 1 : 0);
            check($sformatf("mid_x_k%0d", k), int'(x_a), (k == 4) ? 1 : 0);
        end

        // PIX_DIV=1 instance.
        check("b_rst_x", int'(x_b), 0);
        check("b_rst_hsync", int'(hs_b), 1);
        check("b_rst_vsync", int'(vs_b), 1);
        check("b_rst_p_tick", int'(pt_b), 0);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_p_tick_first", int'(pt_b), 1);
        check("b_x_first", int'(x_b), 1);

        n = 0;
        while (!ft_b && n < 9000) begin
            @(negedge clk);
            n++;
        end
        check("b_frame_tick_found", int'(ft_b), 1);
        check("b_frame_tick_x", int'(x_b), 799);
        check("b_frame_tick_y", int'(y_b), 9);

        vs_low = 0; vs_min = 1023; vs_max = 0; ft_cnt = 0; ft_at = 0; lt_cnt = 0;
        first_lt = 0; hs_low = 0; pt_zero = 0; incoh = 0;
        for (int i = 1; i <= 8000; i++) begin
            @(negedge clk);
            xi = int'(x_b);
            yi = int'(y_b);
            if (i == 1) begin
                check("b_wrap_x", xi, 0);
                check("b_wrap_y", yi, 0);
                check("b_wrap_video_on", int'(vo_b), 1);
            end
            if (!vs_b) begin
                vs_low++;
                if (yi < vs_min) vs_min = yi;
                if (yi > vs_max) vs_max = yi;
            end
            if (!hs_b) hs_low++;
            if (!pt_b) pt_zero++;
            if (ft_b) begin
                ft_cnt++;
                ft_at = i;
            end
            if (lt_b) begin
                lt_cnt++;
                if (first_lt == 0) first_lt = i;
            end
            if (vo_b !== ((xi < 640 && yi < 4) ? 1'b1 : 1'b0)) incoh++;
            if (vs_b !== ((yi >= 6 && yi <= 7) ? 1'b0 : 1'b1)) incoh++;
            if (hs_b !== ((xi >= 656 && xi <= 751) ? 1'b0 : 1'b1)) incoh++;
        end
        check("b_vsync_low_clks", vs_low, 1600);
        check("b_vsync_first_y", vs_min, 6);
        check("b_vsync_last_y", vs_max, 7);
        check("b_hsync_low_clks", hs_low, 960);
        check("b_p_tick_zero_clks", pt_zero, 0);
        check("b_frame_tick_count", ft_cnt, 1);
        check("b_frame_period", ft_at, 8000);
        check("b_line_tick_count", lt_cnt, 10);
        check("b_line_period", first_lt, 800);
        check("b_incoherent", incoh, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
